irq_ctl: RTL and testbench
==========================

IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 SHALL provide parameter NSRC, default 8, meaning the number of interrupt sources (legal range 2..16).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL provide port src, input, NSRC bits: asynchronous peripheral interrupt lines, rising-edge significant.
REQ-005 SHALL provide port iack, input, 1 bit: interrupt acknowledge from the core control FSM; held high from interrupt entry until return.
REQ-006 SHALL provide port irq, output, 1 bit: interrupt request to the core control FSM.
REQ-007 SHALL provide port cause, output, 4 bits: index of the source being requested or serviced.
REQ-008 SHALL provide ports wr_en (input, 1), addr (input, 2), wr_data (input, 32), rd_data (output, 32): register access port.

Function
REQ-009 Each src bit SHALL pass through a two-flop synchronizer plus a previous-value flop; a rising edge SHALL set that bit's pending flag one edge after the second synchronizer stage goes high.
REQ-010 Timing: src high before edge E0 SHALL make PEND visible after E2 and irq high after E3 (FSM idle, source unmasked).
REQ-011 Register map: addr 0 MASK (read/write, bits NSRC-1:0, 1 = enabled); addr 1 PEND (read, write-1-to-clear); addr 2 CAUSE (read: bit 31 = in-service flag, bits 3:0 = cause); addr 3 STATUS (read: bits 1:0 = FSM state encoding).
REQ-012 Unimplemented bits SHALL read 0; writes to addr 2 and 3 SHALL be ignored.
REQ-013 rd_data SHALL be registered: it reflects the register selected by addr at the previous edge (1-cycle read latency).
REQ-014 If a new edge and a write-1-to-clear hit the same PEND bit in one cycle, set SHALL win.
REQ-015 FSM states and encodings: IDLE=0, REQ=1, SERV=2, GAP=3.
REQ-016 IDLE: if (PEND & MASK) is nonzero, latch the lowest-index such bit into cause, assert irq, and go to REQ; otherwise stay.
REQ-017 REQ: irq held high; on iack=1, deassert irq at the same edge, clear the PEND bit for cause, and go to SERV.
REQ-018 In REQ, clearing MASK or PEND for the latched source SHALL NOT withdraw irq or change cause, because the request is already committed.
REQ-019 SERV: irq=0, in-service flag = 1; on iack=0 (return from interrupt), go to GAP.
REQ-020 GAP: one cycle with irq=0, then unconditionally go to IDLE.
- GAP guarantees the core sees irq=0 and iack=0 for at least one cycle before re-arbitration.
REQ-021 iack=1 observed in IDLE or GAP SHALL be ignored (no state change).
REQ-022 New edges arriving in any state SHALL accumulate in PEND; there is no nesting, so at most one source is in service.
REQ-023 A source edge on the in-service source during SERV SHALL re-set its PEND bit, to be serviced after GAP.
REQ-024 cause SHALL hold its value from entry into REQ until the next entry into REQ.

Reset
REQ-025 While rst=1, the following SHALL hold immediately, independent of clk:
- state = IDLE;
- irq = 0; cause = 0;
- MASK = 0; PEND = 0; rd_data = 0;
- all synchronizer and previous-value flops = 0.
REQ-026 Reset asserted mid-REQ or mid-SERV SHALL abandon the request with no PEND write-back; first arbitration SHALL occur at the first edge after rst falls.
REQ-027 A src line already high at reset release SHALL NOT generate an edge; it first must go low, then high.

Verification
REQ-028 Basic: MASK=0xFF; pulse src[3] before E0; hold iack=0 -> irq=1 after E3, cause=3; then iack=1 one cycle later -> irq=0, PEND[3]=0, CAUSE reads 0x80000003.
REQ-029 Priority: src[5] and src[2] rise in the same cycle -> cause=2 serviced first; after iack 1->0 plus GAP -> irq reasserts with cause=5.
REQ-030 Mask: MASK=0x00, pulse src[1] -> PEND=0x02 and irq stays 0; then write MASK=0x02 -> irq=1 two edges after the write (write edge, then IDLE arbitration).
REQ-031 Set-wins: write PEND=0x10 in the same cycle src[4] sets its flag -> PEND[4]=1 afterwards.
REQ-032 Reset mid-operation: assert rst while in SERV with PEND=0x40 -> irq=0, PEND=0, STATUS=0 immediately; release rst with src steady high -> no irq.
REQ-033 Commit: in REQ, write MASK=0 and PEND=all-ones -> irq stays 1 and cause is unchanged until iack=1.

Source files
------------

// File: rtl/irq_ctl.sv
// Interrupt controller: per-source edge capture, MASK/PEND registers, and a
// single-level IDLE/REQ/SERV/GAP handshake with the core's iack line.
module irq_ctl #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic            iack,
   output logic            irq,
   output logic [3:0]      cause,
   input  logic            wr_en,
   input  logic [1:0]      addr,
   input  logic [31:0]     wr_data,
   output logic [31:0]     rd_data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SERV = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [NSRC-1:0] sync1, sync2, prev;
   logic [NSRC-1:0] armed;
   logic [1:0]      settle;
   logic [1:0]      state;
   logic [NSRC-1:0] mask, pend;

   logic [NSRC-1:0] rise, pend_nx, wr_clr, ack_clr;
   logic            hit;
   logic [3:0]      sel;
   logic [31:0]     rd_nx;
   logic            settled;
   logic            unused_wr;

   assign unused_wr = ^wr_data[31:NSRC];
   assign settled   = (settle == 2'd2);

   // A line must be seen low after the chain has settled before it can
   // produce an edge, so a line held high across reset stays silent.
   assign rise = sync2 & ~prev & armed;

   always_comb begin
      hit = |(pend & mask);
      sel = 4'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pend[i] && mask[i]) sel = 4'(i);
      end
   end

   always_comb begin
      wr_clr  = '0;
      ack_clr = '0;
      if (wr_en && addr == 2'd1) wr_clr = wr_data[NSRC-1:0];
      if (state == S_REQ && iack) ack_clr = {{(NSRC-1){1'b0}}, 1'b1} << cause;
      // New edges are OR-ed in last so a set beats any clear in the same cycle.
      pend_nx = (pend & ~wr_clr & ~ack_clr) | rise;
   end

   always_comb begin
      rd_nx = 32'd0;
      case (addr)
         2'd0: rd_nx = 32'(mask);
         2'd1: rd_nx = 32'(pend);
         2'd2: rd_nx = {state == S_SERV, 27'd0, cause};
         2'd3: rd_nx = {30'd0, state};
         default: rd_nx = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         prev   <= '0;
         armed  <= '0;
         settle <= 2'd0;
      end else begin
         sync1 <= src;
         sync2 <= sync1;
         prev  <= sync2;
         if (!settled) settle <= settle + 2'd1;
         armed <= armed | ({NSRC{settled}} & ~sync2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask    <= '0;
         pend    <= '0;
         rd_data <= 32'd0;
      end else begin
         if (wr_en && addr == 2'd0) mask <= wr_data[NSRC-1:0];
         pend    <= pend_nx;
         rd_data <= rd_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         irq   <= 1'b0;
         cause <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hit) begin
                  cause <= sel;
                  irq   <= 1'b1;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (iack) begin
                  irq   <= 1'b0;
                  state <= S_SERV;
               end
            end
            S_SERV: begin
               if (!iack) state <= S_GAP;
            end
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed scenarios plus random traffic, every cycle
// compared with a sample-history reference model.
module tb_irq_ctl;
   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src;
   logic            iack;
   logic            irq;
   logic [3:0]      cause;
   logic            wr_en;
   logic [1:0]      addr;
   logic [31:0]     wr_data;
   logic [31:0]     rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_ctl #(.NSRC(NSRC)) dut (
      .clk(clk), .rst(rst), .src(src), .iack(iack), .irq(irq), .cause(cause),
      .wr_en(wr_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: state numbers are the architectural encodings.
   int              m_state;
   int              m_cause;
   bit              m_irq;
   logic [NSRC-1:0] m_mask, m_pend;
   logic [31:0]     m_rd;
   logic [NSRC-1:0] hist[$];   // src sampled at each edge since reset release

   task automatic model_reset();
      m_state = 0; m_cause = 0; m_irq = 0;
      m_mask = '0; m_pend = '0; m_rd = 32'd0;
      hist.delete();
   endtask

   task automatic model_step();
      int k, lowest, ns;
      logic [NSRC-1:0] rise, clr;
      if (rst) return;
      hist.push_back(src);
      k = hist.size();
      // A rise sampled at edges k-3 -> k-2 lands in PEND at edge k.
      rise = (k >= 4) ? (hist[k-3] & ~hist[k-4]) : '0;
      case (addr)
         2'd0: m_rd = 32'(m_mask);
         2'd1: m_rd = 32'(m_pend);
         2'd2: m_rd = {m_state == 2, 27'd0, 4'(m_cause)};
         default: m_rd = 32'(m_state);
      endcase
      lowest = -1;
      for (int i = 0; i < NSRC; i++)
         if (lowest < 0 && m_pend[i] && m_mask[i]) lowest = i;
      clr = '0;
      ns = m_state;
      case (m_state)
         0: if (lowest >= 0) begin m_cause = lowest; m_irq = 1; ns = 1; end
         1: if (iack) begin m_irq = 0; clr[m_cause] = 1'b1; ns = 2; end
         2: if (!iack) ns = 3;
         default: ns = 0;
      endcase
      m_state = ns;
      if (wr_en && addr == 2'd1) clr = clr | wr_data[NSRC-1:0];
      m_pend = (m_pend & ~clr) | rise;
      if (wr_en && addr == 2'd0) m_mask = wr_data[NSRC-1:0];
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("irq", 32'(irq), 32'(m_irq));
      check("cause", 32'(cause), 32'(m_cause));
      check("rd_data", rd_data, m_rd);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wait_irq(input string tag, input int budget);
      for (int i = 0; i < budget && !irq; i++) cyc();
      check(tag, 32'(irq), 32'd1);
   endtask

   task automatic ack_cycle();
      iack = 1'b1; cyc(); cyc();
      iack = 1'b0; repeat (3) cyc();
   endtask

   // Called right after cyc() returns at a falling edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_cause", 32'(cause), 32'd0);
      check("rst_rd", rd_data, 32'd0);
      model_reset();
      wr_en = 1'b0; iack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; src = '0; iack = 1'b0; wr_en = 1'b0; addr = 2'd0; wr_data = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("init_irq", 32'(irq), 32'd0);
      check("init_cause", 32'(cause), 32'd0);
      check("init_rd", rd_data, 32'd0);
      rst = 1'b0;
      repeat (5) cyc();

      // Basic request / acknowledge with exact edge timing.
      wr(2'd0, 32'hFF);
      repeat (3) cyc();
      src[3] = 1'b1; cyc();
      src[3] = 1'b0; cyc(); cyc();
      check("basic_pre", 32'(irq), 32'd0);
      cyc();
      check("basic_irq", 32'(irq), 32'd1);
      check("basic_cause", 32'(cause), 32'd3);
      iack = 1'b1; addr = 2'd2; cyc();
      check("basic_ack", 32'(irq), 32'd0);
      cyc();
      check("basic_cause_rd", rd_data, 32'h8000_0003);
      addr = 2'd1; cyc();
      check("basic_pend", rd_data, 32'd0);
      iack = 1'b0; repeat (3) cyc();

      // Priority: lowest index first, the other after GAP.
      src = 8'h24;
      wait_irq("prio_irq1", 8);
      check("prio_first", 32'(cause), 32'd2);
      src = '0;
      iack = 1'b1; cyc(); cyc(); iack = 1'b0;
      wait_irq("prio_irq2", 8);
      check("prio_second", 32'(cause), 32'd5);
      ack_cycle();

      // Masked source stays pending, then fires two edges after unmasking.
      wr(2'd0, 32'h0);
      src[1] = 1'b1; repeat (4) cyc();
      src = '0; addr = 2'd1; repeat (2) cyc();
      check("mask_pend", rd_data, 32'h2);
      check("mask_noirq", 32'(irq), 32'd0);
      wr(2'd0, 32'h2);
      check("mask_wr_edge", 32'(irq), 32'd0);
      cyc();
      check("mask_irq", 32'(irq), 32'd1);
      ack_cycle();

      // Set beats write-1-to-clear on the same edge.
      wr(2'd0, 32'h0);
      src[4] = 1'b1; cyc(); cyc();
      wr(2'd1, 32'h10);
      src = '0; addr = 2'd1; cyc();
      check("set_wins", rd_data & 32'h10, 32'h10);
      wr(2'd1, 32'hFF);

      // Committed request survives MASK and PEND clears.
      wr(2'd0, 32'hFF);
      src[6] = 1'b1;
      wait_irq("commit_irq", 8);
      check("commit_cause0", 32'(cause), 32'd6);
      wr(2'd0, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      check("commit_hold", 32'(irq), 32'd1);
      check("commit_cause", 32'(cause), 32'd6);
      iack = 1'b1; cyc();
      check("commit_ack", 32'(irq), 32'd0);

      // Re-edge on the in-service source, then reset in SERV.
      src[6] = 1'b0; repeat (3) cyc();
      src[6] = 1'b1; repeat (4) cyc();
      addr = 2'd3; repeat (2) cyc();
      check("serv_state", rd_data, 32'd2);
      addr = 2'd1; repeat (2) cyc();
      check("serv_pend", rd_data, 32'h40);
      do_reset();
      wr(2'd0, 32'hFF);
      repeat (8) cyc();
      check("rst_steady_irq", 32'(irq), 32'd0);
      addr = 2'd1; repeat (2) cyc();
      check("rst_steady_pend", rd_data, 32'd0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [NSRC-1:0] flip;
         if (n % 1000 == 999) do_reset();
         flip = '0;
         for (int b = 0; b < NSRC; b++) flip[b] = ($urandom % 8 == 0);
         src = src ^ flip;
         if (!iack && m_irq && $urandom % 3 == 0) iack = 1'b1;
         else if (iack && $urandom % 4 == 0) iack = 1'b0;
         wr_en   = ($urandom % 6 == 0);
         addr    = 2'($urandom % 4);
         wr_data = $urandom;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
